// File: rtl/bus_responder.sv
// Memory-bus target for cpu_core: decodes the multiplexed address/data bus and
// serves a local word RAM, a countdown timer with interrupt, and wait states.
module bus_responder #(
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] IO_BASE     = 16'hFF00
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Data_out,
    input  logic        ALE,
    input  logic        nME,
    input  logic        nOE,
    input  logic        RnW,
    output logic [15:0] Data_in,
    output logic        nWait,
    output logic        nIRQ
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_XFER, S_HOLD} state_t;

    localparam logic [3:0] WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t      r_state, w_next;
    logic [3:0]  r_wcnt, w_wcnt_next;
    logic [15:0] r_addr;
    logic [15:0] r_rdata;
    logic [15:0] r_tload;
    logic [1:0]  r_tctrl;
    logic [15:0] r_count;
    logic        r_pending;
    logic        r_nirq;
    logic [15:0] r_mem [2**ADDR_BITS];

    logic                 w_is_ram;
    logic [15:0]          w_io_off;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_commit;
    logic                 w_expire;
    logic [15:0]          w_rd_io;

    assign w_is_ram = (r_addr < IO_BASE);
    assign w_io_off = r_addr - IO_BASE;
    assign w_idx    = r_addr[ADDR_BITS-1:0];
    // A write lands only on the edge that leaves XFER normally; ALE there aborts it.
    assign w_commit = (r_state == S_XFER) && !ALE && !RnW;
    assign w_expire = r_tctrl[0] && (r_count == 16'd0);

    // Access sequencing: next state and wait-counter
    always_comb begin
        w_next      = r_state;
        w_wcnt_next = r_wcnt;
        if (ALE) begin
            w_next = S_ADDR;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_IDLE;
                S_ADDR: begin
                    if (!nME) begin
                        if (WAIT_STATES == 0) begin
                            w_next = S_XFER;
                        end else begin
                            w_next      = S_WAIT;
                            w_wcnt_next = WS_INIT;
                        end
                    end else begin
                        w_next = S_ADDR;
                    end
                end
                S_WAIT: begin
                    if (nME) begin
                        w_next = S_IDLE;
                    end else if (r_wcnt == 4'd0) begin
                        w_next = S_XFER;
                    end else begin
                        w_wcnt_next = r_wcnt - 4'd1;
                    end
                end
                S_XFER: w_next = S_HOLD;
                S_HOLD: w_next = nME ? S_IDLE : S_HOLD;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Register-block read mux
    always_comb begin
        w_rd_io = 16'h0000;
        case (w_io_off)
            16'd0:   w_rd_io = r_tload;
            16'd1:   w_rd_io = {14'd0, r_tctrl};
            16'd2:   w_rd_io = {15'd0, r_pending};
            default: w_rd_io = 16'h0000;
        endcase
    end

    // State, address latch and read-data capture
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_wcnt  <= 4'd0;
            r_addr  <= 16'h0000;
            r_rdata <= 16'h0000;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt_next;
            if (ALE) begin
                r_addr <= Data_out;
            end
            if (w_next == S_XFER) begin
                r_rdata <= w_is_ram ? r_mem[w_idx] : w_rd_io;
            end
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge Clock) begin
        if (w_commit && w_is_ram) begin
            r_mem[w_idx] <= Data_out;
        end
    end

    // Timer, pending flag and registered interrupt line
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_tload   <= 16'h0000;
            r_tctrl   <= 2'b00;
            r_count   <= 16'h0000;
            r_pending <= 1'b0;
            r_nirq    <= 1'b1;
        end else begin
            if (w_commit && !w_is_ram && (w_io_off == 16'd0)) begin
                r_tload <= Data_out;
                r_count <= Data_out;
            end else if (r_tctrl[0]) begin
                r_count <= (r_count == 16'd0) ? r_tload : r_count - 16'd1;
            end
            if (w_commit && !w_is_ram && (w_io_off == 16'd1)) begin
                r_tctrl <= Data_out[1:0];
            end
            // An expiry in the same cycle as a clear keeps the flag set.
            if (w_expire) begin
                r_pending <= 1'b1;
            end else if (w_commit && !w_is_ram && (w_io_off == 16'd2) && Data_out[0]) begin
                r_pending <= 1'b0;
            end
            r_nirq <= ~(r_pending & r_tctrl[1]);
        end
    end

    assign nWait = (r_state != S_WAIT);
    assign nIRQ  = r_nirq;

    // Read data is visible only while the core is actually reading
    always_comb begin
        Data_in = 16'h0000;
        if (((r_state == S_XFER) || (r_state == S_HOLD)) && RnW && !nOE) begin
            Data_in = r_rdata;
        end else begin
            Data_in = 16'h0000;
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: one instance with two wait states, one with none,
// checked against a word-array memory model and an arithmetic timer schedule.
module tb_bus_responder;

    localparam logic [15:0] IOB = 16'hFF00;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Data_out = 16'h0000;
    logic        ALE = 1'b0, nME0 = 1'b1, nME2 = 1'b1, nOE = 1'b1, RnW = 1'b1;
    logic [15:0] Din0, Din2;
    logic        nW0, nW2, nI0, nI2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_commit = 0;
    int ec = 0;
    int last_clr = 0;
    int period = 4;

    logic [15:0] m0 [1024];
    logic [15:0] m2 [1024];
    int          q2 [$];

    bus_responder #(.ADDR_BITS(10), .WAIT_STATES(2), .IO_BASE(IOB)) u_dut2 (
        .Clock(Clock), .Reset(Reset), .Data_out(Data_out), .ALE(ALE), .nME(nME2),
        .nOE(nOE), .RnW(RnW), .Data_in(Din2), .nWait(nW2), .nIRQ(nI2));

    bus_responder #(.ADDR_BITS(10), .WAIT_STATES(0), .IO_BASE(IOB)) u_dut0 (
        .Clock(Clock), .Reset(Reset), .Data_out(Data_out), .ALE(ALE), .nME(nME0),
        .nOE(nOE), .RnW(RnW), .Data_in(Din0), .nWait(nW0), .nIRQ(nI0));

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Most recent timer expiry at or before edge m, or -1 if none yet.
    function automatic int last_exp(input int m);
        if (m < ec + period) return -1;
        return ec + period * ((m - ec) / period);
    endfunction

    function automatic logic pend_m(input int m);
        int le;
        le = last_exp(m);
        return (le >= 0) && (le >= last_clr);
    endfunction

    task automatic irq_chk(input string tag);
        chk(tag, {15'd0, nI2}, {15'd0, ~pend_m(cyc - 1)});
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            irq_chk("nirq_sched");
        end
    endtask

    task automatic addr_phase(input logic [15:0] a);
        ALE = 1'b1;
        Data_out = a;
        @(negedge Clock);
        ALE = 1'b0;
    endtask

    task automatic data_phase(input int sel, input logic rnw, input logic [15:0] wd,
                              input logic [15:0] exp);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        if (sel == 0) nME0 = 1'b0; else nME2 = 1'b0;
        RnW = rnw;
        nOE = ~rnw;
        Data_out = wd;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge Clock);
            if (((sel == 0) ? nW0 : nW2) == 1'b1) done = 1'b1;
            else n++;
        end
        chk("wait_cycles", 16'(n), (sel == 0) ? 16'd0 : 16'd2);
        last_commit = cyc + 1;
        chk(rnw ? "rd_xfer" : "wr_din_zero", (sel == 0) ? Din0 : Din2, rnw ? exp : 16'h0000);
        @(negedge Clock);
        if (rnw) begin
            chk("rd_hold", (sel == 0) ? Din0 : Din2, exp);
            nOE = 1'b1;
            #1;
            chk("rd_noe_high", (sel == 0) ? Din0 : Din2, 16'h0000);
        end
        nME0 = 1'b1;
        nME2 = 1'b1;
        nOE  = 1'b1;
        RnW  = 1'b1;
        @(negedge Clock);
    endtask

    task automatic access(input int sel, input logic [15:0] a, input logic rnw,
                          input logic [15:0] wd, input logic [15:0] exp);
        addr_phase(a);
        data_phase(sel, rnw, wd, exp);
    endtask

    task automatic wr(input int sel, input logic [15:0] a, input logic [15:0] d);
        access(sel, a, 1'b0, d, 16'h0000);
        if (a < IOB) begin
            if (sel == 0) m0[a[9:0]] = d; else m2[a[9:0]] = d;
        end
    endtask

    task automatic rd(input int sel, input logic [15:0] a);
        access(sel, a, 1'b1, 16'h0000, (sel == 0) ? m0[a[9:0]] : m2[a[9:0]]);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        int          idx;

        repeat (2) @(negedge Clock);
        chk("rst_nwait", {15'd0, nW2}, 16'd1);
        chk("rst_din", Din2, 16'h0000);
        chk("rst_nirq", {15'd0, nI2}, 16'd1);
        chk("rst_din0", Din0, 16'h0000);
        Reset = 1'b0;
        @(negedge Clock);
        access(2, IOB, 1'b1, 16'h0, 16'h0000);
        access(2, IOB + 16'd1, 1'b1, 16'h0, 16'h0000);
        access(2, IOB + 16'd2, 1'b1, 16'h0, 16'h0000);

        // two wait states: write then read back
        wr(2, 16'h0012, 16'hBEEF);
        rd(2, 16'h0012);

        // zero wait states and address aliasing
        wr(0, 16'h0412, 16'h1234);
        rd(0, 16'h0012);

        // ALE during WAIT aborts the write in progress
        wr(2, 16'h0005, 16'hAAAA);
        addr_phase(16'h0005);
        nME2 = 1'b0;
        RnW = 1'b0;
        nOE = 1'b1;
        Data_out = 16'h5555;
        @(negedge Clock);
        chk("abort_in_wait", {15'd0, nW2}, 16'd0);
        ALE = 1'b1;
        Data_out = 16'h0006;
        @(negedge Clock);
        ALE = 1'b0;
        data_phase(2, 1'b0, 16'h7777, 16'h0000);
        m2[6] = 16'h7777;
        rd(2, 16'h0005);
        rd(2, 16'h0006);

        // random RAM traffic with aliased read-back
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom_range(0, 32'hFEFF));
            d = 16'($urandom);
            wr(2, a, d);
            q2.push_back(int'(a[9:0]));
        end
        for (int i = 0; i < 12; i++) begin
            idx = q2[$urandom_range(0, q2.size() - 1)];
            a = {6'($urandom_range(0, 63)), 10'(idx)};
            rd(2, a);
        end

        // reset in the middle of a write's wait phase
        addr_phase(16'h0012);
        nME2 = 1'b0;
        RnW = 1'b0;
        Data_out = 16'h0BAD;
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        chk("midrst_nwait", {15'd0, nW2}, 16'd1);
        chk("midrst_din", Din2, 16'h0000);
        chk("midrst_nirq", {15'd0, nI2}, 16'd1);
        @(negedge Clock);
        Reset = 1'b0;
        nME2 = 1'b1;
        RnW = 1'b1;
        @(negedge Clock);
        rd(2, 16'h0012);

        // register block and unmapped IO
        wr(2, IOB, 16'h0003);
        wr(2, IOB + 16'd1, 16'hFFFE);
        access(2, IOB, 1'b1, 16'h0, 16'h0003);
        access(2, IOB + 16'd1, 1'b1, 16'h0, 16'h0002);
        access(2, IOB + 16'd7, 1'b1, 16'h0, 16'h0000);
        wr(2, IOB + 16'd7, 16'hFFFF);
        access(2, IOB + 16'd7, 1'b1, 16'h0, 16'h0000);
        access(2, IOB, 1'b1, 16'h0, 16'h0003);
        access(2, IOB + 16'd1, 1'b1, 16'h0, 16'h0002);
        access(2, IOB + 16'd2, 1'b1, 16'h0, 16'h0000);

        // timer: period LOAD+1, interrupt follows pending by one cycle
        wr(2, IOB, 16'h0003);
        period = 4;
        wr(2, IOB + 16'd1, 16'h0003);
        ec = last_commit;
        irq_chk("nirq_after_en");
        tick(12);
        while (((cyc + 5 - ec) % period) != 1) tick(1);
        wr(2, IOB + 16'd2, 16'h0001);
        last_clr = last_commit;
        chk("clr_nirq_high", {15'd0, nI2}, 16'd1);
        tick(8);
        while (((cyc + 5 - ec) % period) != 0) tick(1);
        wr(2, IOB + 16'd2, 16'h0001);
        last_clr = last_commit;
        chk("clr_coincide", {15'd0, nI2}, 16'd0);
        tick(4);
        access(2, IOB + 16'd2, 1'b1, 16'h0, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Target end of the CPU external memory bus: a responder that decodes the multiplexed address/data bus driven by the core and answers read and write strobes.
- Contains a local word RAM, wait-state insertion on nWait, and a countdown timer that raises nIRQ.
- Sits beside cpu_core at chip/testbench top level. Its outputs connect to the core's Data_in, nWait and nIRQ.

Parameters:
- ADDR_BITS, 10, RAM depth is 2**ADDR_BITS 16-bit words.
- WAIT_STATES, 1, number of nWait-low cycles per access (0..15).
- IO_BASE, 16'hFF00, base address of the register block.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Data_out  in  16  core bus output; carries the address while ALE=1 and write data otherwise.
- ALE  in  1  address latch enable.
- nME  in  1  memory enable, active low; frames one access.
- nOE  in  1  output enable, active low.
- RnW  in  1  1=read, 0=write.
- Data_in  out  16  read data returned to the core.
- nWait  out  1  active-low wait request.
- nIRQ  out  1  active-low interrupt request.

Behaviour:
- Clock/reset: one clock (Clock). Reset is asynchronous and active-high.
- Reset values: state=IDLE, addr=0, Data_in=16'h0000, nWait=1, nIRQ=1, TIMER_LOAD=0, TIMER_CTRL=0, counter=0, pending=0. RAM contents are not reset.
- FSM states: IDLE, ADDR, WAIT, XFER, HOLD.
- ALE sampled 1 in any state: latch Data_out into addr and go to ADDR. This aborts any access in progress; an aborted write commits nothing.
- ADDR: on nME sampled 0, go to WAIT with wcnt=WAIT_STATES-1. If WAIT_STATES=0, go directly to XFER.
- WAIT:
  - nWait=0 for exactly WAIT_STATES cycles.
  - Decrement wcnt; go to XFER after the cycle where wcnt=0.
  - nME sampled 1 during WAIT: go to IDLE, no write.
- XFER (one cycle):
  - nWait=1.
  - Read data is registered on entry to XFER.
  - Write commits on the edge ending XFER, using Data_out sampled at that edge, only if RnW=0.
  - Next state is HOLD.
- HOLD: stay until nME sampled 1, then go to IDLE. nWait=1.
- nWait is 1 in every state except WAIT. It is driven purely from state, so it is glitch-free.
- Data_in = rdata when state is XFER or HOLD, RnW=1 and nOE=0; otherwise 16'h0000.
- Address decode:
  - addr < IO_BASE: RAM word addr[ADDR_BITS-1:0]. Upper address bits alias onto the same RAM.
  - IO_BASE+0 TIMER_LOAD (rw, 16 bit). A write also loads the counter.
  - IO_BASE+1 TIMER_CTRL (rw). bit0 = timer enable, bit1 = irq enable; other bits read 0.
  - IO_BASE+2 STATUS. bit0 = pending; writing 1 to bit0 clears it.
  - Other IO addresses: read 16'h0000, writes ignored.
- Timer:
  - When enabled, decrements by 1 per Clock.
  - On the cycle it is 0, it reloads from TIMER_LOAD and sets pending.
  - TIMER_LOAD=0 with enable=1: pending is set every cycle.
  - Disabled: counter holds its value.
- Simultaneous set and write-1-clear of pending: set wins.
- nIRQ = ~(pending & TIMER_CTRL[1]), registered. It changes one cycle after pending or irq-enable changes.
- RnW or nOE changing mid-access: Data_in follows combinationally. Only the RnW value sampled at the end of XFER decides whether a write commits.

Test Plan:
- WAIT_STATES=2; ALE with Data_out=16'h0012; nME low with RnW=0, Data_out=16'hBEEF; then read 16'h0012 -> nWait low exactly 2 cycles per access, then 1; read returns Data_in=16'hBEEF in XFER/HOLD; Data_in=0 once nOE goes high.
- WAIT_STATES=0; write 16'h1234 to 16'h0412 with ADDR_BITS=10, then read 16'h0012 -> nWait never low; read returns 16'h1234 (alias).
- Write 16'hAAAA to 16'h0005; ALE pulses with a new address during WAIT -> RAM[5] unchanged; new access to the new address completes normally.
- TIMER_LOAD=3, TIMER_CTRL=3 -> pending set every 4 cycles; nIRQ=0 one cycle after pending sets; write 1 to STATUS -> nIRQ=1 next cycle, reasserts on the next expiry; clear coincident with expiry keeps nIRQ=0.
- Reset asserted mid-WAIT during a write -> nWait=1, Data_in=0 and nIRQ=1 immediately (asynchronous); write not committed; a subsequent read of that address returns the old data.
- Read IO_BASE+7 and write it -> Data_in=16'h0000; register values unchanged.
